pipe_controller: RTL and testbench
==================================

# pipe_controller

Pipelined successor to the single-cycle MIPS decode controller. It decodes `op`/`funct` in D, then carries the control bundle and ALU code through the E, M and W pipeline registers. Per-stage stall/flush and a multi-cycle multiply/divide sequencer are included. It sits between the instruction register and the datapath, alongside the hazard unit.

## Interface
Parameters:
- `ALU_W`, 4: ALU control width; must be at least 3. Codes are zero-extended.
- `MDU_LAT`, 32: cycles a mult/div occupies E; must be at least 1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `op_d`  in  6  opcode of the D-stage instruction.
- `funct_d`  in  6  funct field of the D-stage instruction.
- `valid_d`  in  1  D holds a real instruction.
- `stall_e`  in  1  hold the E register.
- `flush_e`  in  1  load a bubble into E.
- `ctrl_e`, `ctrl_m`, `ctrl_w`  out  11  registered control bundle per stage.
- `alu_control_e`  out  ALU_W  ALU code for E.
- `valid_e`, `valid_m`, `valid_w`  out  1  stage holds a real instruction.
- `md_start`  out  1  one-cycle pulse on the first E cycle of a mult/div.
- `md_busy`  out  1  mult/div sequencing; upstream must freeze F/D.

## Operation
- Control bundle bits, MSB first:
  - 10 `reg_write`, 9 `reg_dst`, 8 `alu_src`, 7 `branch`, 6 `mem_write`, 5 `mem_to_reg`
  - 4 `jump`, 3 `mem_read`, 2 `hilo_write`, 1 `is_div`, 0 `illegal`
- Decode (combinational from D):
  - R-type (op 0x00), funct add 0x20 / sub 0x22 / and 0x24 / or 0x25 / slt 0x2a → ctrl 0x600, ALU 2 / 6 / 0 / 1 / 7.
  - mult (funct 0x18) → ctrl 0x004; div (funct 0x1a) → ctrl 0x006; ALU 0.
  - lw 0x23 → 0x528, ALU 2.
  - sw 0x2b → 0x140, ALU 2.
  - beq 0x04 → 0x080, ALU 6.
  - addi 0x08 → 0x500, ALU 2.
  - j 0x02 → 0x010, ALU 0.
  - Any other op/funct → 0x001, ALU 0.
- Bubble: ctrl 0, ALU 0, valid 0. `valid_d`=0 decodes as a bubble.
- E register update, in priority order:
  - `md_busy` → hold; `stall_e` and `flush_e` are ignored.
  - `flush_e` → bubble (flush wins over `stall_e`).
  - `stall_e` → hold.
  - Otherwise load the decoded D.
- M loads E every cycle, except it loads a bubble whenever E holds (stall or `md_busy`). W loads M every cycle; M and W never stall.
- MDU sequencer:
  - Down-counter `cnt`, width ceil(log2(MDU_LAT)) with a minimum of 1, reset 0.
  - On the edge a mult/div is loaded into E: `cnt` ← MDU_LAT−1 and `md_start` ← 1 for the next cycle only.
  - `md_busy` = (`cnt` ≠ 0). `cnt` decrements each cycle while nonzero.
  - The instruction occupies E for exactly MDU_LAT cycles, then advances.
  - MDU_LAT=1 gives a pulse on `md_start` with no busy cycles.
  - D inputs are ignored while `md_busy`.

## Timing
- Reset values: all `ctrl_*`, `alu_control_e`, `valid_*`, `md_start`, `md_busy` and `cnt` are 0.
- `rst` mid-operation aborts any mult/div and empties all stages in the next cycle.
- Latency with no stalls: D→E 1 edge, D→M 2 edges, D→W 3 edges.
- `md_busy` is combinational from `cnt` (no input-to-output path). All other outputs are registered.
- A mult/div immediately following a mult/div is loaded only after the first leaves E.

## Configuration
- `CTRL_MDU_EN` defined: mult/div decode as above and the sequencer is built.
- `CTRL_MDU_EN` undefined:
  - funct 0x18/0x1a decode as illegal (0x001).
  - `cnt` is removed; `md_start` and `md_busy` are tied to 0.

## Test plan
- Reset, then lw with `valid_d`=1 → next cycle `ctrl_e`=0x528, `alu_control_e`=2, `valid_e`=1; three edges after load `ctrl_w`=0x528, `valid_w`=1.
- add in E, `stall_e`=1 for 2 cycles → `ctrl_e` stays 0x600; `ctrl_m`=0 and `valid_m`=0 for those 2 cycles; add reaches M on the edge after `stall_e` falls.
- `stall_e`=1 and `flush_e`=1 in the same cycle → next cycle `ctrl_e`=0, `valid_e`=0.
- MDU_LAT=4, `CTRL_MDU_EN` defined, div issued → `ctrl_e`=0x006 for 4 cycles; `md_start`=1 in the first only; `md_busy`=1 in the first 3; `ctrl_m`=0 in those 4 cycles; `ctrl_m`=0x006 on the 5th.
- op 0x3f → `ctrl_e`=0x001, ALU 0. With `CTRL_MDU_EN` undefined, mult → `ctrl_e`=0x001 and `md_busy` stays 0.
- `rst` asserted in the 2nd cycle of a div (MDU_LAT=32) → next cycle all outputs 0, `md_busy`=0; an add issued afterwards flows normally.

Source files
------------

// File: rtl/pipe_controller.sv
// pipe_controller: D-stage decode plus E/M/W control pipeline; CTRL_MDU_EN builds the mult/div sequencer
module pipe_controller #(
    parameter int ALU_W   = 4,
    parameter int MDU_LAT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op_d,
    input  logic [5:0]       funct_d,
    input  logic             valid_d,
    input  logic             stall_e,
    input  logic             flush_e,
    output logic [10:0]      ctrl_e,
    output logic [10:0]      ctrl_m,
    output logic [10:0]      ctrl_w,
    output logic [ALU_W-1:0] alu_control_e,
    output logic             valid_e,
    output logic             valid_m,
    output logic             valid_w,
    output logic             md_start,
    output logic             md_busy
);
    if (ALU_W < 3 || MDU_LAT < 1) begin : g_param_check
        $error("pipe_controller: ALU_W must be >= 3 and MDU_LAT >= 1");
    end

    logic [10:0] dec_ctrl;
    logic [2:0]  dec_alu;
    logic        hold_e;
    logic        load_e;

    always_comb begin
        dec_ctrl = 11'h001;
        dec_alu  = 3'd0;
        case (op_d)
            6'h00: case (funct_d)
                6'h20: {dec_ctrl, dec_alu} = {11'h600, 3'd2};
                6'h22: {dec_ctrl, dec_alu} = {11'h600, 3'd6};
                6'h24: {dec_ctrl, dec_alu} = {11'h600, 3'd0};
                6'h25: {dec_ctrl, dec_alu} = {11'h600, 3'd1};
                6'h2a: {dec_ctrl, dec_alu} = {11'h600, 3'd7};
`ifdef CTRL_MDU_EN
                6'h18: {dec_ctrl, dec_alu} = {11'h004, 3'd0};
                6'h1a: {dec_ctrl, dec_alu} = {11'h006, 3'd0};
`endif
                default: ;
            endcase
            6'h23: {dec_ctrl, dec_alu} = {11'h528, 3'd2};
            6'h2b: {dec_ctrl, dec_alu} = {11'h140, 3'd2};
            6'h04: {dec_ctrl, dec_alu} = {11'h080, 3'd6};
            6'h08: {dec_ctrl, dec_alu} = {11'h500, 3'd2};
            6'h02: {dec_ctrl, dec_alu} = {11'h010, 3'd0};
            default: ;
        endcase
        if (!valid_d) {dec_ctrl, dec_alu} = '0;
    end

    // E holds while the MDU runs or when stalled without a flush; M then takes a bubble
    assign hold_e = md_busy | (stall_e & ~flush_e);
    assign load_e = ~md_busy & ~stall_e & ~flush_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_e        <= '0;
            ctrl_m        <= '0;
            ctrl_w        <= '0;
            alu_control_e <= '0;
            valid_e       <= 1'b0;
            valid_m       <= 1'b0;
            valid_w       <= 1'b0;
        end else begin
            if (!hold_e) begin
                ctrl_e        <= flush_e ? '0 : dec_ctrl;
                alu_control_e <= flush_e ? '0 : ALU_W'(dec_alu);
                valid_e       <= ~flush_e & valid_d;
            end
            ctrl_m  <= hold_e ? '0 : ctrl_e;
            valid_m <= ~hold_e & valid_e;
            ctrl_w  <= ctrl_m;
            valid_w <= valid_m;
        end
    end

`ifdef CTRL_MDU_EN
    localparam int CW = MDU_LAT > 1 ? $clog2(MDU_LAT) : 1;
    logic [CW-1:0] cnt;
    assign md_busy = cnt != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            md_start <= 1'b0;
        end else begin
            md_start <= load_e & dec_ctrl[2];
            cnt      <= (load_e & dec_ctrl[2]) ? CW'(MDU_LAT - 1) : cnt - CW'(md_busy);
        end
    end
`else
    assign md_start = 1'b0;
    assign md_busy  = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: stage-occupancy model checked every cycle plus literal checks of key cases
module tb_pipe_controller;
`ifdef CTRL_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif
    localparam int LAT = 4;
    localparam logic [10:0] MD_ILL = 11'h001;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [10:0] ctrl;
        logic [2:0]  alu;
    } ins_t;

    typedef struct packed {
        logic [10:0] ctrl;
        logic [2:0]  alu;
        logic        v;
    } st_t;

    localparam ins_t NOP  = {6'h00, 6'h00, 11'h001, 3'd0};
    localparam ins_t ADD  = {6'h00, 6'h20, 11'h600, 3'd2};
    localparam ins_t SUB  = {6'h00, 6'h22, 11'h600, 3'd6};
    localparam ins_t AND_ = {6'h00, 6'h24, 11'h600, 3'd0};
    localparam ins_t OR_  = {6'h00, 6'h25, 11'h600, 3'd1};
    localparam ins_t SLT  = {6'h00, 6'h2a, 11'h600, 3'd7};
    localparam ins_t LW   = {6'h23, 6'h15, 11'h528, 3'd2};
    localparam ins_t SW   = {6'h2b, 6'h00, 11'h140, 3'd2};
    localparam ins_t BEQ  = {6'h04, 6'h2a, 11'h080, 3'd6};
    localparam ins_t ADDI = {6'h08, 6'h3f, 11'h500, 3'd2};
    localparam ins_t J    = {6'h02, 6'h00, 11'h010, 3'd0};
    localparam ins_t ILL  = {6'h3f, 6'h20, 11'h001, 3'd0};
    localparam ins_t BADF = {6'h00, 6'h3f, 11'h001, 3'd0};
    localparam ins_t MULT = {6'h00, 6'h18, MDU_EN ? 11'h004 : MD_ILL, 3'd0};
    localparam ins_t DIV  = {6'h00, 6'h1a, MDU_EN ? 11'h006 : MD_ILL, 3'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op_d = '0;
    logic [5:0]  funct_d = '0;
    logic        valid_d = 1'b0;
    logic        stall_e = 1'b0;
    logic        flush_e = 1'b0;
    logic [10:0] ctrl_e, ctrl_m, ctrl_w;
    logic [3:0]  alu_control_e;
    logic        valid_e, valid_m, valid_w, md_start, md_busy;

    always #5 clk = ~clk;

    pipe_controller #(.ALU_W(4), .MDU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .op_d(op_d), .funct_d(funct_d), .valid_d(valid_d),
        .stall_e(stall_e), .flush_e(flush_e), .ctrl_e(ctrl_e), .ctrl_m(ctrl_m),
        .ctrl_w(ctrl_w), .alu_control_e(alu_control_e), .valid_e(valid_e),
        .valid_m(valid_m), .valid_w(valid_w), .md_start(md_start), .md_busy(md_busy)
    );

    int   n_pass = 0;
    int   n_tot  = 0;
    bit   chk_on = 1'b0;
    ins_t cur = NOP;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: which instruction sits in each stage, and how long E's occupant has been there
    st_t me, mm, mw;
    int  age;
    logic m_md, m_busy, m_start, m_hold;
    assign m_md    = me.v && (me.ctrl == 11'h004 || me.ctrl == 11'h006);
    assign m_busy  = MDU_EN && m_md && age < LAT - 1;
    assign m_start = MDU_EN && m_md && age == 0;
    assign m_hold  = m_busy || (stall_e && !flush_e);

    always @(posedge clk) begin
        if (rst) begin
            me  <= '0;
            mm  <= '0;
            mw  <= '0;
            age <= 0;
        end else begin
            mw <= mm;
            mm <= m_hold ? '0 : me;
            if (m_hold) age <= age + 1;
            else begin
                me  <= (flush_e || !valid_d) ? '0 : {cur.ctrl, cur.alu, 1'b1};
                age <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("ctrl_e", 32'(ctrl_e), 32'(me.ctrl));
            check("ctrl_m", 32'(ctrl_m), 32'(mm.ctrl));
            check("ctrl_w", 32'(ctrl_w), 32'(mw.ctrl));
            check("alu_e", 32'(alu_control_e), 32'(me.alu));
            check("valid_e", 32'(valid_e), 32'(me.v));
            check("valid_m", 32'(valid_m), 32'(mm.v));
            check("valid_w", 32'(valid_w), 32'(mw.v));
            check("md_start", 32'(md_start), 32'(m_start));
            check("md_busy", 32'(md_busy), 32'(m_busy));
        end
    end

    task automatic drive(input ins_t i, input logic v, input logic s, input logic f);
        cur     = i;
        op_d    = i.op;
        funct_d = i.funct;
        valid_d = v;
        stall_e = s;
        flush_e = f;
        @(posedge clk);
        #2;
    endtask

    ins_t tbl[14];

    initial begin
        tbl = '{ADD, SUB, AND_, OR_, SLT, LW, SW, BEQ, ADDI, J, ILL, BADF, MULT, DIV};
        drive(NOP, 0, 0, 0);
        chk_on = 1'b1;
        drive(NOP, 0, 0, 0);
        check("rst_ctrl_e", 32'(ctrl_e), 32'h0);
        check("rst_valid_w", 32'(valid_w), 32'h0);
        check("rst_md_busy", 32'(md_busy), 32'h0);
        rst = 1'b0;

        drive(LW, 1, 0, 0);
        check("lw_ctrl_e", 32'(ctrl_e), 32'h528);
        check("lw_alu_e", 32'(alu_control_e), 32'h2);
        check("lw_valid_e", 32'(valid_e), 32'h1);
        drive(NOP, 0, 0, 0);
        drive(NOP, 0, 0, 0);
        check("lw_ctrl_w", 32'(ctrl_w), 32'h528);
        check("lw_valid_w", 32'(valid_w), 32'h1);

        drive(ADD, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            drive(SUB, 1, 1, 0);
            check("stall_ctrl_e", 32'(ctrl_e), 32'h600);
            check("stall_ctrl_m", 32'(ctrl_m), 32'h0);
            check("stall_valid_m", 32'(valid_m), 32'h0);
        end
        drive(SUB, 1, 0, 0);
        check("unstall_ctrl_m", 32'(ctrl_m), 32'h600);
        check("unstall_alu_e", 32'(alu_control_e), 32'h6);
        drive(AND_, 1, 1, 1);
        check("flush_ctrl_e", 32'(ctrl_e), 32'h0);
        check("flush_valid_e", 32'(valid_e), 32'h0);

        drive(ILL, 1, 0, 0);
        check("ill_ctrl_e", 32'(ctrl_e), 32'h001);
        check("ill_alu_e", 32'(alu_control_e), 32'h0);
        drive(BADF, 1, 0, 0);
        check("badf_ctrl_e", 32'(ctrl_e), 32'h001);

        for (int k = 0; k < 28; k++)
            drive(tbl[k % 14], 1'(k % 7 != 5), 1'(k % 3 == 1), 1'(k % 5 == 3));
        for (int k = 0; k < 6; k++) drive(NOP, 0, 0, 0);

        drive(DIV, 1, 0, 0);
`ifdef CTRL_MDU_EN
        check("div_ctrl_e", 32'(ctrl_e), 32'h006);
        check("div_start", 32'(md_start), 32'h1);
        check("div_busy", 32'(md_busy), 32'h1);
        for (int k = 0; k < 2; k++) begin
            drive(ADD, 1, 1, 1);
            check("div_hold_ctrl_e", 32'(ctrl_e), 32'h006);
            check("div_hold_start", 32'(md_start), 32'h0);
            check("div_hold_busy", 32'(md_busy), 32'h1);
            check("div_hold_ctrl_m", 32'(ctrl_m), 32'h0);
        end
        drive(ADD, 1, 0, 0);
        check("div_last_ctrl_e", 32'(ctrl_e), 32'h006);
        check("div_last_busy", 32'(md_busy), 32'h0);
        check("div_last_ctrl_m", 32'(ctrl_m), 32'h0);
        drive(ADD, 1, 0, 0);
        check("div_out_ctrl_m", 32'(ctrl_m), 32'h006);
        check("div_next_ctrl_e", 32'(ctrl_e), 32'h600);
`else
        check("div_ill_ctrl_e", 32'(ctrl_e), 32'h001);
        drive(MULT, 1, 0, 0);
        check("mult_ill_ctrl_e", 32'(ctrl_e), 32'h001);
        check("mult_busy", 32'(md_busy), 32'h0);
        drive(ADD, 1, 0, 0);
        check("mult_ill_ctrl_m", 32'(ctrl_m), 32'h001);
`endif
        drive(MULT, 1, 0, 0);
        for (int k = 0; k < 4; k++) drive(DIV, 1, 0, 0);
        drive(MULT, 1, 1, 0);
        drive(NOP, 0, 0, 0);
        drive(SLT, 1, 0, 1);
        for (int k = 0; k < 6; k++) drive(NOP, 0, 0, 0);

        drive(DIV, 1, 0, 0);
        drive(NOP, 0, 0, 0);
        rst = 1'b1;
        drive(NOP, 0, 0, 0);
        check("rst_div_ctrl_e", 32'(ctrl_e), 32'h0);
        check("rst_div_valid_e", 32'(valid_e), 32'h0);
        check("rst_div_ctrl_m", 32'(ctrl_m), 32'h0);
        check("rst_div_busy", 32'(md_busy), 32'h0);
        check("rst_div_start", 32'(md_start), 32'h0);
        rst = 1'b0;
        drive(ADD, 1, 0, 0);
        drive(NOP, 0, 0, 0);
        drive(NOP, 0, 0, 0);
        check("post_rst_ctrl_w", 32'(ctrl_w), 32'h600);
        check("post_rst_valid_w", 32'(valid_w), 32'h1);
        drive(NOP, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
